// File: rtl/tl_pkg.sv
// Shared traffic-light encodings: per-direction light codes, controller
// phase codes and width helpers used by the controllers and their benches.
package tl_pkg;

  // Light code driven for each direction.
  localparam logic [1:0] LT_GREEN  = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_RED    = 2'b10;

  // Controller phase; also the FSM state encoding.
  localparam logic [1:0] PH_GREEN  = 2'b00;
  localparam logic [1:0] PH_YELLOW = 2'b01;
  localparam logic [1:0] PH_ALLRED = 2'b10;

  // Width of a direction index: at least one bit even for two directions.
  function automatic int dir_w(input int n_dir);
    return (n_dir > 2) ? $clog2(n_dir) : 1;
  endfunction

  // Width of the phase cycle counter, sized for the longest timed phase.
  function automatic int cnt_w(input int t_max_green, input int t_yel, input int t_allred);
    int m;
    m = t_max_green;
    if (t_yel > m) m = t_yel;
    if (t_allred > m) m = t_allred;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Round-robin next-direction picker: returns the first requesting direction
// after cur_dir (wrapping), or cur_dir+1 when nobody else is requesting.
module tl_rr_pick
  import tl_pkg::*;
#(
  parameter int N_DIR = 2,
  localparam int DW = dir_w(N_DIR)
) (
  input  logic [N_DIR-1:0] req,
  input  logic [DW-1:0]    cur_dir,
  output logic [DW-1:0]    next_dir
);

  logic found;

  // Scan cur_dir+1 .. cur_dir+N_DIR-1 modulo N_DIR and keep the first hit.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned and no latch is inferred.
    found    = 1'b0;
    next_dir = DW'((int'(cur_dir) + 1) % N_DIR);
    for (int k = 1; k < N_DIR; k++) begin
      int idx;
      idx = (int'(cur_dir) + k) % N_DIR;
      if (!found && req[idx]) begin
        found    = 1'b1;
        next_dir = DW'(idx);
      end
    end
  end

endmodule

// File: rtl/tl_cntr_n.sv
// N-direction traffic-light controller: sensor-driven green hand-off with
// minimum/maximum green, fixed yellow and all-red clearance, plus
// emergency preemption toward a chosen direction.
module tl_cntr_n
  import tl_pkg::*;
#(
  parameter int N_DIR       = 2,
  parameter int T_MIN_GREEN = 3,
  parameter int T_MAX_GREEN = 8,
  parameter int T_YEL       = 2,
  parameter int T_ALLRED    = 1,
  localparam int DW = dir_w(N_DIR)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_DIR-1:0]   T,
  input  logic               pre_req,
  input  logic [DW-1:0]      pre_dir,
  output logic [2*N_DIR-1:0] L,
  output logic [DW-1:0]      cur_dir,
  output logic [1:0]         phase
);

  localparam int CW = cnt_w(T_MAX_GREEN, T_YEL, T_ALLRED);

  localparam logic [CW-1:0] MIN_LAST = CW'(T_MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_LAST = CW'(T_MAX_GREEN - 1);
  localparam logic [CW-1:0] YEL_LAST = CW'(T_YEL - 1);
  localparam logic [CW-1:0] AR_LAST  = CW'((T_ALLRED > 0) ? T_ALLRED - 1 : 0);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};
  localparam logic [DW:0]   NDIR_W   = (DW + 1)'(N_DIR);

  logic [1:0]       state, state_nx;
  logic [DW-1:0]    next_dir, next_dir_nx, cur_dir_nx, rr_dir;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [N_DIR-1:0] cur_mask;
  logic             pre_ok, cur_t, others;

  tl_rr_pick #(.N_DIR(N_DIR)) u_rr_pick (
    .req      (T),
    .cur_dir  (cur_dir),
    .next_dir (rr_dir)
  );

  // Sensor summary for the owning direction and for everyone else.
  always_comb begin
    for (int i = 0; i < N_DIR; i++) begin
      cur_mask[i] = (DW'(i) == cur_dir);
    end
    cur_t  = |(T & cur_mask);
    others = |(T & ~cur_mask);
    // Out-of-range preemption targets are ignored.
    pre_ok = pre_req && ({1'b0, pre_dir} < NDIR_W);
  end

  // Next-state, next-direction and hand-off decisions.
  always_comb begin
    state_nx    = state;
    next_dir_nx = next_dir;
    cur_dir_nx  = cur_dir;
    unique case (state)
      PH_GREEN: begin
        if (pre_ok && (pre_dir != cur_dir)) begin
          state_nx    = PH_YELLOW;
          next_dir_nx = pre_dir;
        end else if (pre_ok) begin
          // Preemption toward the current owner pins green.
          state_nx = PH_GREEN;
        end else if ((cnt >= MIN_LAST) && (!cur_t || ((cnt >= MAX_LAST) && others))) begin
          state_nx    = PH_YELLOW;
          next_dir_nx = rr_dir;
        end
      end
      PH_YELLOW: begin
        if (pre_ok) next_dir_nx = pre_dir;
        if (cnt == YEL_LAST) begin
          if (T_ALLRED > 0) begin
            state_nx = PH_ALLRED;
          end else begin
            state_nx   = PH_GREEN;
            cur_dir_nx = next_dir_nx;
          end
        end
      end
      PH_ALLRED: begin
        if (pre_ok) next_dir_nx = pre_dir;
        if (cnt == AR_LAST) begin
          state_nx   = PH_GREEN;
          cur_dir_nx = next_dir_nx;
        end
      end
      default: begin
        state_nx   = PH_GREEN;
        cur_dir_nx = '0;
      end
    endcase

    // Counter restarts on every state entry and saturates while holding.
    if (state_nx != state) cnt_nx = '0;
    else if (cnt != CNT_SAT) cnt_nx = cnt + 1'b1;
    else cnt_nx = cnt;
  end

  // State registers; asynchronous reset lands on direction 0 green.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= PH_GREEN;
      cur_dir  <= '0;
      next_dir <= DW'(1);
      cnt      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
      state    <= state_nx;
      cur_dir  <= cur_dir_nx;
      next_dir <= next_dir_nx;
      cnt      <= cnt_nx;
    end
  end

  // Lights decoded from registered state only; non-owners are always red.
  always_comb begin
    for (int i = 0; i < N_DIR; i++) begin
      L[2*i +: 2] = LT_RED;
      if (DW'(i) == cur_dir) begin
        unique case (state)
          PH_GREEN:  L[2*i +: 2] = LT_GREEN;
          PH_YELLOW: L[2*i +: 2] = LT_YELLOW;
          default:   L[2*i +: 2] = LT_RED;
        endcase
      end
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_tl_cntr_n.sv
// Directed bench for tl_cntr_n with three directions, min green 3,
// max green 6, yellow 2 and all-red 1.
module tb_tl_cntr_n;
  import tl_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [2:0] T;
  logic       pre_req;
  logic [1:0] pre_dir;
  logic [5:0] L;
  logic [1:0] cur_dir;
  logic [1:0] phase;

  int checks;
  int failures;

  localparam logic [5:0] L_G0 = 6'b101000;
  localparam logic [5:0] L_Y0 = 6'b101001;
  localparam logic [5:0] L_R0 = 6'b101010;
  localparam logic [5:0] L_G1 = 6'b100010;
  localparam logic [5:0] L_G2 = 6'b001010;

  tl_cntr_n #(
    .N_DIR(3), .T_MIN_GREEN(3), .T_MAX_GREEN(6), .T_YEL(2), .T_ALLRED(1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .T       (T),
    .pre_req (pre_req),
    .pre_dir (pre_dir),
    .L       (L),
    .cur_dir (cur_dir),
    .phase   (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] exp_l,
                       input logic [1:0] exp_ph, input logic [1:0] exp_dir);
    checks++;
    assert (L === exp_l && phase === exp_ph && cur_dir === exp_dir)
    else begin
      failures++;
      $error("FAIL %s: got L=%b phase=%b cur_dir=%0d, want L=%b phase=%b cur_dir=%0d",
             tag, L, phase, cur_dir, exp_l, exp_ph, exp_dir);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, confirm it acted before any edge, release.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check(tag, L_G0, PH_GREEN, 2'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b1; T = 3'b000; pre_req = 1'b0; pre_dir = 2'd0;
    #2;

    // Async reset before the first clock edge.
    do_reset("reset_async");

    // Idle: min green 3, yellow 2, all-red 1, hand to direction 1.
    check("idle_g0_c0", L_G0, PH_GREEN, 2'd0); step();
    check("idle_g0_c1", L_G0, PH_GREEN, 2'd0); step();
    check("idle_g0_c2", L_G0, PH_GREEN, 2'd0); step();
    check("idle_y0_c0", L_Y0, PH_YELLOW, 2'd0); step();
    check("idle_y0_c1", L_Y0, PH_YELLOW, 2'd0); step();
    check("idle_ar0",   L_R0, PH_ALLRED, 2'd0); step();
    check("idle_g1",    L_G1, PH_GREEN, 2'd1);

    // Only direction 0 waiting: green held, no timeout.
    T = 3'b001;
    do_reset("reset_hold");
    for (int i = 0; i < 20; i++) begin
      check("hold_g0", L_G0, PH_GREEN, 2'd0); step();
    end

    // Contention 0 and 2: max green 6, then direction 2, skipping 1.
    T = 3'b101;
    do_reset("reset_cont");
    for (int i = 0; i < 6; i++) begin
      check("cont_g0", L_G0, PH_GREEN, 2'd0); step();
    end
    check("cont_y0_c0", L_Y0, PH_YELLOW, 2'd0); step();
    check("cont_y0_c1", L_Y0, PH_YELLOW, 2'd0); step();
    check("cont_ar0",   L_R0, PH_ALLRED, 2'd0); step();
    check("cont_g2",    L_G2, PH_GREEN, 2'd2);

    // Preemption to direction 1 at green cnt 0 bypasses min green.
    T = 3'b001;
    do_reset("reset_pre1");
    pre_req = 1'b1; pre_dir = 2'd1;
    check("pre1_g0", L_G0, PH_GREEN, 2'd0); step();
    check("pre1_y0_c0", L_Y0, PH_YELLOW, 2'd0); step();
    check("pre1_y0_c1", L_Y0, PH_YELLOW, 2'd0); step();
    check("pre1_ar0",   L_R0, PH_ALLRED, 2'd0); step();
    check("pre1_g1",    L_G1, PH_GREEN, 2'd1); step();
    check("pre1_g1_pin", L_G1, PH_GREEN, 2'd1);
    pre_req = 1'b0;

    // Out-of-range preemption target is ignored.
    T = 3'b001;
    do_reset("reset_pre3");
    pre_req = 1'b1; pre_dir = 2'd3;
    for (int i = 0; i < 8; i++) begin
      check("pre3_g0", L_G0, PH_GREEN, 2'd0); step();
    end
    pre_req = 1'b0;

    // Preemption to the owner suppresses the idle exit; release hands off next edge.
    T = 3'b000;
    do_reset("reset_pin");
    pre_req = 1'b1; pre_dir = 2'd0;
    for (int i = 0; i < 6; i++) begin
      check("pin_g0", L_G0, PH_GREEN, 2'd0); step();
    end
    pre_req = 1'b0;
    check("pin_g0_rel", L_G0, PH_GREEN, 2'd0); step();
    check("pin_y0", L_Y0, PH_YELLOW, 2'd0);

    // Preemption during yellow retargets the hand-off without changing timing.
    T = 3'b000;
    do_reset("reset_ypre");
    step(); step(); step();
    check("ypre_y0_c0", L_Y0, PH_YELLOW, 2'd0);
    pre_req = 1'b1; pre_dir = 2'd2;
    step();
    pre_req = 1'b0;
    check("ypre_y0_c1", L_Y0, PH_YELLOW, 2'd0); step();
    check("ypre_ar0",   L_R0, PH_ALLRED, 2'd0); step();
    check("ypre_g2",    L_G2, PH_GREEN, 2'd2);

    // Reset during yellow cnt 1 acts immediately; full min green afterwards.
    T = 3'b000;
    do_reset("reset_mid_a");
    step(); step(); step(); step();
    check("mid_y0_c1", L_Y0, PH_YELLOW, 2'd0);
    do_reset("reset_mid_async");
    check("mid_g0_c0", L_G0, PH_GREEN, 2'd0); step();
    check("mid_g0_c1", L_G0, PH_GREEN, 2'd0); step();
    check("mid_g0_c2", L_G0, PH_GREEN, 2'd0); step();
    check("mid_y0",    L_Y0, PH_YELLOW, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tl_cntr_n.md
TL_CNTR_N -- requirements
Module: tl_cntr_n

Interface
REQ-001 Parameter N_DIR, default 2, number of directions (2..4).
REQ-002 Parameter T_MIN_GREEN, default 3, minimum green cycles (>=1).
REQ-003 Parameter T_MAX_GREEN, default 8, green cycles before forced hand-off under contention (>=T_MIN_GREEN).
REQ-004 Parameter T_YEL, default 2, yellow cycles (>=1).
REQ-005 Parameter T_ALLRED, default 1, all-red clearance cycles (>=0).
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 T  input  N_DIR  traffic sensor per direction; 1 = vehicle waiting.
REQ-009 pre_req  input  1  preemption (emergency) request, level.
REQ-010 pre_dir  input  DW=max(1,clog2(N_DIR))  preemption target direction.
REQ-011 L  output  2*N_DIR  light per direction, L[2i+1:2i] for direction i; 00 green, 01 yellow, 10 red.
REQ-012 cur_dir  output  DW  direction currently owning green/yellow.
REQ-013 phase  output  2  00 GREEN, 01 YELLOW, 10 ALLRED.

Function
REQ-014 FSM states GREEN, YELLOW, ALLRED; one cycle counter cnt, cleared on every state entry, incremented each cycle in state, width clog2(max(T_MAX_GREEN,T_YEL,T_ALLRED)+1), saturating.
REQ-015 L is registered-state decoded: GREEN -> cur_dir 00; YELLOW -> cur_dir 01; ALLRED -> cur_dir 10; all other directions 10 in every state.
REQ-016 GREEN exit to YELLOW when cnt >= T_MIN_GREEN-1 and (T[cur_dir]==0, or cnt >= T_MAX_GREEN-1 and any other T bit set).
REQ-017 T[cur_dir]==1 with no other T bit set holds GREEN indefinitely (no timeout); cnt saturates.
REQ-018 On GREEN->YELLOW, next_dir latched: first direction with T set searching cur_dir+1, cur_dir+2, ... modulo N_DIR; if none set, cur_dir+1 mod N_DIR.
REQ-019 YELLOW lasts exactly T_YEL cycles, then ALLRED.
REQ-020 ALLRED lasts exactly T_ALLRED cycles, then GREEN with cur_dir <= next_dir; T_ALLRED=0 goes YELLOW -> GREEN directly.
REQ-021 Preemption: pre_req=1 in GREEN with pre_dir != cur_dir -> YELLOW next cycle regardless of min-green, next_dir <= pre_dir.
REQ-022 pre_req=1 in GREEN with pre_dir == cur_dir -> stay GREEN; all exits suppressed while asserted.
REQ-023 pre_req=1 in YELLOW or ALLRED -> next_dir <= pre_dir; timing of YELLOW/ALLRED unchanged.
REQ-024 pre_dir >= N_DIR -> pre_req ignored.
REQ-025 Preemption overrides T-based selection when both occur in the same cycle.
REQ-026 Inputs T, pre_req, pre_dir are sampled only on clk rising edges; no combinational input-to-output path.

Reset
REQ-027 reset_n=0 asynchronously forces phase GREEN, cur_dir 0, next_dir 1, cnt 0; L = direction 0 green, all others red.
REQ-028 Reset asserted mid-operation (any state, any cnt) takes effect immediately without waiting for clk; operation restarts at GREEN direction 0 with full min-green on release.

Structure
REQ-029 Shared package tl_pkg holds light encodings (GREEN/YELLOW/RED) and phase encodings; also used by existing tl_cntr benches.
REQ-030 Round-robin next-direction search is one combinational sub-module, tl_rr_pick (inputs req vector, cur_dir; output next_dir).

Verification (N_DIR=3, T_MIN_GREEN=3, T_MAX_GREEN=6, T_YEL=2, T_ALLRED=1)
REQ-031 Reset pulse -> L=6'b101000, phase 00, cur_dir 0 asynchronously, before next clk edge.
REQ-032 T=3'b001 held 20 cycles -> L stays 6'b101000 throughout.
REQ-033 T=3'b000 from reset release -> GREEN 3 cycles, YELLOW 2 (L=6'b101001), ALLRED 1 (L=6'b101010), then cur_dir 1 green (L=6'b100010).
REQ-034 T=3'b101 held -> dir0 GREEN 6 cycles, YELLOW 2, ALLRED 1, then cur_dir 2 green (L=6'b001010), dir1 skipped.
REQ-035 pre_req=1, pre_dir=1 asserted at GREEN cnt 0 with T=3'b001 -> YELLOW next cycle, then ALLRED, then cur_dir 1 green; pre_dir=3 instead -> no change.
REQ-036 reset_n=0 during YELLOW cnt 1 -> immediately L=6'b101000, phase 00; after release dir0 holds green >=3 cycles.
